mem_arbiter: RTL and testbench

- Shares the single 20-bit memory bus between the 8088 core (master 0) and a DMA/video requester (master 1).
- Sequences the core by driving its `ce` input: the core is stalled while DMA owns the bus.
- Guarantees that no core write or port strobe is lost and that memory read data matches the core's address when `ce` resumes.
- Sits between the core, the DMA engine and the synchronous memory (1-clock read latency).

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose: shares the 20-bit memory bus between the 8088 core (master 0) and a DMA/video requester (master 1).
// Latency: the first dma_ack comes 1 cycle after the grant decision; 1 turn cycle on release; read data 1 clock after address.
// Backpressure: the core is stalled via cpu_ce while DMA owns the bus; DMA waits (dma_ack=0) until it is granted.
//
// Ports:
//   clock, reset_n                   clock, synchronous active-low reset
//   cpu_address/out/we/pr/pw         core bus request; cpu_ce core clock enable, cpu_in read data
//   dma_req/address/out/we           DMA request; dma_ack access done, dma_rvalid/dma_in read return
//   mem_address/out/we, mem_in       synchronous memory (1-clock read latency)
//   io_pr, io_pw                     port strobes, passed only while the core owns the bus
//
// Optional build macro: ARB_BURST_LIMIT_EN -- when defined, a DMA burst is cut after MAX_BURST
// acked cycles so the core gets CPU_SLOTS cycles even under continuous DMA demand.

module mem_arbiter #(
   parameter int MAX_BURST = 16,
   parameter int CPU_SLOTS = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [19:0] cpu_address,
   input  logic [7:0]  cpu_out,
   input  logic        cpu_we,
   input  logic        cpu_pr,
   input  logic        cpu_pw,
   output logic        cpu_ce,
   output logic [7:0]  cpu_in,
   input  logic        dma_req,
   input  logic [19:0] dma_address,
   input  logic [7:0]  dma_out,
   input  logic        dma_we,
   output logic        dma_ack,
   output logic        dma_rvalid,
   output logic [7:0]  dma_in,
   output logic [19:0] mem_address,
   output logic [7:0]  mem_out,
   output logic        mem_we,
   input  logic [7:0]  mem_in,
   output logic        io_pr,
   output logic        io_pw
);

   localparam logic [1:0] S_CPU  = 2'd0;
   localparam logic [1:0] S_DMA  = 2'd1;
   localparam logic [1:0] S_TURN = 2'd2;

`ifdef ARB_BURST_LIMIT_EN
   localparam logic LIMIT_EN = 1'b1;
`else
   localparam logic LIMIT_EN = 1'b0;
`endif

   localparam logic [7:0] SLOT_INIT  = 8'(CPU_SLOTS);
   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [7:0] slot_cnt;
   logic [7:0] burst_cnt;
   logic       rvalid_q;
   logic       sw;
   logic       ack_int;
   logic       burst_done;

   // Hand the bus over only when the core has no strobe in flight this cycle,
   // so a pending write or port access always completes first.
   assign sw = dma_req & ~cpu_we & ~cpu_pr & ~cpu_pw & (slot_cnt == 8'd0);

   assign ack_int = (state == S_DMA) & dma_req;

   // The access acked now is the MAX_BURST-th of this burst: leave after it.
   assign burst_done = LIMIT_EN & ack_int & (burst_cnt >= BURST_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         S_CPU:   if (sw) state_nxt = S_DMA;
         S_DMA:   if (!dma_req || burst_done) state_nxt = S_TURN;
         S_TURN:  state_nxt = S_CPU;
         default: state_nxt = S_CPU;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= S_CPU;
         slot_cnt  <= 8'd0;
         burst_cnt <= 8'd0;
         rvalid_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         rvalid_q <= ack_int & ~dma_we;
         case (state)
            S_CPU: begin
               if (sw)
                  burst_cnt <= 8'd0;
               else if (slot_cnt != 8'd0)
                  slot_cnt <= slot_cnt - 8'd1;
            end
            S_DMA: begin
               if (ack_int && burst_cnt != 8'hFF)
                  burst_cnt <= burst_cnt + 8'd1;
            end
            S_TURN: slot_cnt <= SLOT_INIT;
            default: ;
         endcase
      end
   end

   // Bus mux and strobes. The turn cycle keeps the core address on the bus so
   // mem_in carries core data again by the time cpu_ce returns.
   always_comb begin
      cpu_ce      = 1'b0;
      dma_ack     = 1'b0;
      mem_address = cpu_address;
      mem_out     = cpu_out;
      mem_we      = 1'b0;
      io_pr       = 1'b0;
      io_pw       = 1'b0;
      if (reset_n) begin
         case (state)
            S_CPU: begin
               cpu_ce = ~sw;
               mem_we = cpu_we;
               io_pr  = cpu_pr;
               io_pw  = cpu_pw;
            end
            S_DMA: begin
               dma_ack     = dma_req;
               mem_address = dma_address;
               mem_out     = dma_out;
               mem_we      = dma_we & dma_req;
            end
            default: ;
         endcase
      end
   end

   assign dma_rvalid = rvalid_q & reset_n;
   assign cpu_in     = mem_in;
   assign dma_in     = mem_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter against a cycle-level ownership model and a memory model.
// Latency: samples outputs 1 time unit after the falling edge; inputs change only after the falling edge.
// Backpressure: DMA requests are held until acked; core strobes only follow a cycle with cpu_ce=1.

module tb_mem_arbiter;

   localparam int MAX_BURST = 16;
   localparam int CPU_SLOTS = 2;
`ifdef ARB_BURST_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   localparam int OWN_CORE = 0;
   localparam int OWN_DMA  = 1;
   localparam int OWN_TURN = 2;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [19:0] cpu_address;
   logic [7:0]  cpu_out;
   logic        cpu_we, cpu_pr, cpu_pw;
   logic        cpu_ce;
   logic [7:0]  cpu_in;
   logic        dma_req;
   logic [19:0] dma_address;
   logic [7:0]  dma_out;
   logic        dma_we;
   logic        dma_ack, dma_rvalid;
   logic [7:0]  dma_in;
   logic [19:0] mem_address;
   logic [7:0]  mem_out;
   logic        mem_we;
   logic [7:0]  mem_in;
   logic        io_pr, io_pw;

   mem_arbiter #(.MAX_BURST(MAX_BURST), .CPU_SLOTS(CPU_SLOTS)) dut (
      .clock(clock), .reset_n(reset_n),
      .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
      .cpu_pr(cpu_pr), .cpu_pw(cpu_pw), .cpu_ce(cpu_ce), .cpu_in(cpu_in),
      .dma_req(dma_req), .dma_address(dma_address), .dma_out(dma_out),
      .dma_we(dma_we), .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_in(dma_in),
      .mem_address(mem_address), .mem_out(mem_out), .mem_we(mem_we), .mem_in(mem_in),
      .io_pr(io_pr), .io_pw(io_pw)
   );

   always #5 clock = ~clock;

   // ---------------- memories ----------------
   logic [7:0] tb_mem    [logic [19:0]];
   logic [7:0] model_mem [logic [19:0]];

   function automatic logic [7:0] init_val(input logic [19:0] a);
      if (a == 20'h12345) return 8'hAA;
      if (a == 20'h12346) return 8'hBB;
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] tb_rd(input logic [19:0] a);
      if (tb_mem.exists(a)) return tb_mem[a];
      return init_val(a);
   endfunction

   function automatic logic [7:0] model_rd(input logic [19:0] a);
      if (model_mem.exists(a)) return model_mem[a];
      return init_val(a);
   endfunction

   // Synchronous memory seen by the DUT: read-before-write, 1 clock latency.
   always @(posedge clock) begin
      mem_in <= tb_rd(mem_address);
      if (mem_we === 1'b1) tb_mem[mem_address] = mem_out;
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int         m_owner = OWN_CORE;
   int         m_guard = 0;     // core cycles still owed before DMA may win
   int         m_burst = 0;     // acked cycles in the current burst
   bit         m_rvalid = 1'b0;
   bit         m_rd_ok = 1'b0;
   logic [7:0] m_rd_exp = 8'h00;
   bit         m_last_ce = 1'b0;

   bit          e_ce, e_ack, e_we, e_pr, e_pw, e_grant, e_rvalid;
   logic [19:0] e_addr;
   logic [7:0]  e_out;
   bit          obs_ack;
   logic [7:0]  rd_seen[$];

   task automatic model_eval();
      e_ce = 0; e_ack = 0; e_we = 0; e_pr = 0; e_pw = 0; e_grant = 0;
      e_addr = cpu_address; e_out = cpu_out;
      e_rvalid = reset_n && m_rvalid;
      if (reset_n) begin
         if (m_owner == OWN_CORE) begin
            e_grant = dma_req && !(cpu_we || cpu_pr || cpu_pw) && (m_guard == 0);
            e_ce = !e_grant;
            e_we = cpu_we; e_pr = cpu_pr; e_pw = cpu_pw;
         end else if (m_owner == OWN_DMA) begin
            e_ack  = dma_req;
            e_addr = dma_address;
            e_out  = dma_out;
            e_we   = dma_we && dma_req;
         end
      end
   endtask

   task automatic model_advance();
      if (!reset_n) begin
         m_owner = OWN_CORE; m_guard = 0; m_burst = 0;
         m_rvalid = 0; m_rd_ok = 0;
      end else begin
         m_rd_exp = model_rd(e_addr);
         m_rd_ok  = 1;
         if (e_we) model_mem[e_addr] = e_out;
         m_rvalid = e_ack && !dma_we;
         case (m_owner)
            OWN_CORE: begin
               if (e_grant) begin m_owner = OWN_DMA; m_burst = 0; end
               else if (m_guard > 0) m_guard--;
            end
            OWN_DMA: begin
               if (e_ack && m_burst < 255) m_burst++;
               if (!dma_req || (LIMIT && e_ack && m_burst >= MAX_BURST)) m_owner = OWN_TURN;
            end
            default: begin m_owner = OWN_CORE; m_guard = CPU_SLOTS; end
         endcase
      end
      m_last_ce = e_ce;
   endtask

   // One clock cycle: inputs already applied after the falling edge.
   task automatic step();
      #1;
      model_eval();
      chk("cpu_ce", cpu_ce, e_ce);
      chk("dma_ack", dma_ack, e_ack);
      chk("dma_rvalid", dma_rvalid, e_rvalid);
      chk("mem_we", mem_we, e_we);
      chk("io_pr", io_pr, e_pr);
      chk("io_pw", io_pw, e_pw);
      if (reset_n) begin
         chk("mem_address", mem_address, e_addr);
         chk("mem_out", mem_out, e_out);
      end
      chk("cpu_in", cpu_in, mem_in);
      chk("dma_in", dma_in, mem_in);
      if (m_rd_ok) chk("mem_in", mem_in, m_rd_exp);
      if (e_rvalid) begin
         chk("dma_rdata", dma_in, m_rd_exp);
         rd_seen.push_back(dma_in);
      end
      obs_ack = dma_ack;
      @(posedge clock);
      model_advance();
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      cpu_we = 0; cpu_pr = 0; cpu_pw = 0; dma_req = 0;
      for (int i = 0; i < n; i++) step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int runs[$];
      int exp_runs[$];
      int run_cur;
      int acks;
      int req_left;

      reset_n = 0; cpu_address = 20'h00100; cpu_out = 8'h00;
      cpu_we = 0; cpu_pr = 0; cpu_pw = 0;
      dma_req = 1; dma_address = 20'h20000; dma_out = 8'h00; dma_we = 0;
      @(negedge clock);

      // Reset held with a DMA request, then release: grant, then ack.
      step(); step();
      reset_n = 1;
      step(); step(); step();
      idle(4);

      // Core write in the same cycle DMA asks: write lands, grant is a cycle late.
      cpu_address = 20'h00100; cpu_out = 8'h3C; cpu_we = 1; dma_req = 1; dma_we = 1;
      dma_address = 20'h00200; dma_out = 8'hC3;
      step();
      cpu_we = 0;
      step(); step();
      idle(4);

      // Two DMA reads of known memory contents.
      rd_seen.delete();
      dma_req = 1; dma_we = 0; dma_address = 20'h12345;
      step(); step();
      dma_address = 20'h12346;
      step();
      dma_req = 0;
      step();
      idle(3);
      chk("dma_rd_cnt", rd_seen.size(), 2);
      if (rd_seen.size() >= 2) begin
         chk("dma_rd0", rd_seen[0], 8'hAA);
         chk("dma_rd1", rd_seen[1], 8'hBB);
      end

      // Continuous demand for 40 acked cycles: record the ack runs.
      dma_req = 1; dma_we = 0; dma_address = 20'h00300;
      run_cur = 0; acks = 0;
      for (int c = 0; c < 300 && acks < 40; c++) begin
         step();
         if (obs_ack) begin run_cur++; acks++; end
         else if (run_cur > 0) begin runs.push_back(run_cur); run_cur = 0; end
      end
      if (run_cur > 0) runs.push_back(run_cur);
      chk("burst_acks", acks, 40);
      if (LIMIT) begin exp_runs.push_back(16); exp_runs.push_back(16); exp_runs.push_back(8); end
      else exp_runs.push_back(40);
      chk("burst_runs", runs.size(), exp_runs.size());
      for (int i = 0; i < exp_runs.size() && i < runs.size(); i++)
         chk($sformatf("burst_run%0d", i), runs[i], exp_runs[i]);
      idle(4);

      // Reset asserted during the 3rd acked DMA cycle.
      dma_req = 1; dma_we = 0; dma_address = 20'h00400;
      step(); step(); step();
      reset_n = 0;
      step();
      chk("rst_ack", obs_ack, 1'b0);
      reset_n = 1; dma_req = 0;
      step(); step();
      idle(2);

      // Randomized traffic.
      req_left = 0;
      for (int c = 0; c < 3000; c++) begin
         reset_n = ($urandom_range(0, 499) != 0);
         cpu_address = 20'h12340 + 20'($urandom_range(0, 15));
         cpu_out = 8'($urandom);
         cpu_we = 0; cpu_pr = 0; cpu_pw = 0;
         if (reset_n && m_last_ce) begin
            case ($urandom_range(0, 9))
               0: cpu_we = 1;
               1: cpu_pr = 1;
               2: cpu_pw = 1;
               default: ;
            endcase
         end
         if (req_left == 0 && $urandom_range(0, 7) == 0) req_left = $urandom_range(1, 24);
         dma_req = (req_left > 0);
         if (req_left > 0 && (obs_ack || $urandom_range(0, 3) == 0)) req_left--;
         dma_address = 20'h12340 + 20'($urandom_range(0, 15));
         dma_out = 8'($urandom);
         dma_we = $urandom_range(0, 1) == 1;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
